// File: rtl/rr_encoder32_5.sv
// Round-robin 32:5 priority encoder with a registered valid/ready output stage.
// The search starts at ptr and wraps; a loaded grant moves ptr just past the winner.
module rr_encoder32_5 (
  input  logic        clk,
  input  logic        reset,
  input  logic        e,
  input  logic [31:0] req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] out_grant
);

  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic [31:0] grant_q, grant_d;

  logic [63:0] req_dbl;
  logic [31:0] req_rot;
  logic [4:0]  offset;
  logic        hit;
  logic [4:0]  found;
  logic        load;

  // Rotate req so that bit ptr lands at position 0, then pick the lowest set bit.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[31:0];
    offset  = 5'd0;
    hit     = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = 5'(i);
        hit    = 1'b1;
      end
    end
    found = ptr_q + offset;
  end

  assign load = !vld_q || out_ready;

  always_comb begin
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    grant_d = grant_q;
    if (load) begin
      if (e && hit) begin
        vld_d   = 1'b1;
        idx_d   = found;
        grant_d = 32'd1 << found;
        ptr_d   = found + 5'd1;
      end else begin
        vld_d   = 1'b0;
        grant_d = 32'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= 5'd0;
      idx_q   <= 5'd0;
      vld_q   <= 1'b0;
      grant_q <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
    end
  end

  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign out_grant = grant_q;

endmodule

// File: doc/rr_encoder32_5.md
# rr_encoder32_5

Round-robin 32:5 priority encoder with a registered valid/ready output stage. It sits in the register-file/datapath area and converts a 32-bit request vector into a 5-bit index, the inverse of the 5:32 write-address decoder. Successive grants rotate fairly among requesters. The one-hot grant it also produces equals what the 5:32 decoder would produce from the same index.

## Interface
- No parameters. Widths are fixed: 32 requests, 5-bit index.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- e  input  1  enable; when 0, no new grant is issued.
- req  input  32  request vector; bit i set means requester i wants a grant. Sampled each cycle.
- out_ready  input  1  consumer accepts the current grant this cycle.
- out_valid  output  1  out_idx/out_grant hold a valid grant.
- out_idx  output  5  index of the granted requester.
- out_grant  output  32  one-hot of out_idx when out_valid=1; all zeros when out_valid=0.

## Operation
- State:
  - ptr[4:0]: search start / priority pointer.
  - Output registers: out_valid, out_idx, out_grant.
- Load condition: `load = !out_valid || out_ready`, meaning the output stage is empty or is being drained this cycle.
- Search: find the first set bit of req scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32). This is combinational from req and ptr.
- On a clock edge when load=1:
  - If e=1 and req≠0:
    - out_valid←1
    - out_idx←found index k
    - out_grant←1<<k
    - ptr←(k+1) mod 32, so index 31 wraps to 0.
  - Otherwise: out_valid←0, out_grant←0. out_idx and ptr hold.
- On a clock edge when load=0 (out_valid=1 and out_ready=0):
  - All registers hold.
  - Changes on req or e are ignored; the granted index is never withdrawn or replaced while stalled.
- A requester that drops its req bit after being granted does not affect a held grant.
- ptr advances only when a grant is loaded. It never advances on an accept with no new grant.
- Invariant: out_grant == (out_valid ? 1<<out_idx : 0) at all times.
- Any asserted request is granted within 32 loads: round-robin, no starvation.

## Timing
- Reset (asynchronous, takes effect immediately): out_valid=0, out_idx=0, out_grant=0, ptr=0.
- Reset mid-operation: a held grant is dropped with no further handshake, and ptr returns to 0.
- After reset deasserts, the first edge with e=1 and req≠0 loads a grant.
- Latency: req sampled at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: with out_ready held at 1 and requests continuously present, one grant per cycle.
- Transfer occurs on an edge where out_valid=1 and out_ready=1. On that same edge the next grant, if any, is loaded. There is no bubble.
- out_ready is ignored when out_valid=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert reset with req=32'hFFFF_FFFF → out_valid=0, out_idx=0, out_grant=0 immediately. After release with e=0, out_valid stays 0.
- Single request: e=1, out_ready=1, req=32'h0000_0100 → one cycle later out_valid=1, out_idx=8, out_grant=32'h0000_0100. Next grant repeats index 8 (ptr=9 wraps round to 8).
- Rotation/wrap: req=32'h8000_0003, out_ready=1 held → successive out_idx 0, 1, 31, 0, 1, 31…
- Stall hold: grant out_idx=5 with out_ready=0. Change req to 32'h0000_0400 for 3 cycles → out_idx stays 5 and out_valid stays 1. Raise out_ready → next out_idx=10.
- Empty/enable: grant outstanding, then out_ready=1 with req=0 (or e=0) → out_valid=0, out_grant=0 next cycle, ptr unchanged. Re-asserting the previous req gives the expected rotated index.
- Exhaustive one-hot: for i=0..31 set req=1<<i and check out_idx=i and out_grant=1<<i. This also cross-checks out_grant against the 5:32 decoder output for the same index.
